ir_transmitter_gen: RTL and testbench

- Parametrised, bus-mapped IR remote-car transmitter. Successor to the fixed 4-bit, single-timing transmitter.
- Holds a command register and a control register. Generates packets periodically or on demand, modulated onto a configurable carrier.
- Packet timing is set per car colour by parameters.
- Sits on the microprocessor bus as a write-only peripheral; drives the IR LED pin.

---
 rtl/ir_pkg.sv | 25 ++
 rtl/ir_carrier_gen.sv | 36 +++
 rtl/ir_transmitter_gen.sv | 170 +++++++++++++++++
 tb/tb_ir_transmitter_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR remote-car transmitter:
// FSM state encoding, register offsets and control-register bit positions.
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      GAP    = 3'd2,
      CARSEL = 3'd3,
      BIT    = 3'd4,
      DONE   = 3'd5
   } ir_state_t;

   localparam logic [7:0] CMD_OFS  = 8'd0;
   localparam logic [7:0] CTRL_OFS = 8'd1;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_TRIG_BIT = 1;

   // Terminal count for a segment lasting n pulse ticks.
   function automatic logic [15:0] last_tick(input int n);
      return 16'(n - 1);
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running clock divider: level toggles every PERIOD clocks and tick flags
// the clock before each wrap (only the wraps that raise level when RISE_ONLY).
module ir_carrier_gen #(
   parameter int PERIOD    = 4,
   parameter bit RISE_ONLY = 1'b1
) (
   input  logic CLK,
   input  logic RESET,
   output logic level,
   output logic tick
);

   localparam logic [31:0] LAST = 32'(PERIOD - 1);

   logic [31:0] cnt_r;
   logic        level_r;
   logic        wrap_s;

   assign wrap_s = (cnt_r == LAST);
   assign tick   = wrap_s && (!level_r || !RISE_ONLY);
   assign level  = level_r;

   // Divider counter and output level.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_r   <= 32'd0;
         level_r <= 1'b0;
      end else if (wrap_s) begin
         cnt_r   <= 32'd0;
         level_r <= !level_r;
      end else begin
         cnt_r   <= cnt_r + 32'd1;
      end
   end

endmodule

// File: rtl/ir_transmitter_gen.sv
// Bus-mapped IR remote-car transmitter with carrier modulation.
// Define IR_CHANGE_TRIGGER_EN to also start a packet when a CMD write changes the value.
module ir_transmitter_gen
   import ir_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR     = 8'h90,
   parameter int         CLK_FREQ_HZ   = 100000000,
   parameter int         CARRIER_HZ    = 36000,
   parameter int         PACKET_HZ     = 10,
   parameter int         CMD_BITS      = 4,
   parameter int         START_PULSES  = 88,
   parameter int         CARSEL_PULSES = 22,
   parameter int         GAP_PULSES    = 40,
   parameter int         ONE_PULSES    = 44,
   parameter int         ZERO_PULSES   = 22
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] BUS_ADDR,
   input  logic [7:0] BUS_DATA,
   input  logic       BUS_WE,
   output logic       IR_LED,
   output logic       BUSY
);

   localparam int         CARRIER_DIV = CLK_FREQ_HZ / (2 * CARRIER_HZ);
   localparam int         PACKET_DIV  = CLK_FREQ_HZ / PACKET_HZ;
   localparam logic [7:0] CMD_ADDR    = BASE_ADDR + CMD_OFS;
   localparam logic [7:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;
   localparam logic [7:0] CMD_MASK    = 8'((9'd1 << CMD_BITS) - 9'd1);
   localparam logic [2:0] LAST_BIT    = 3'(CMD_BITS - 1);

   logic        carrier_s, pulse_s, pkt_tick_s, pkt_level_unused_s;
   logic        cmd_wr_s, ctrl_wr_s, trig_s, chg_s, set_pend_s, burst_s, end_s;
   logic [7:0]  cmd_new_s;
   logic [15:0] limit_s;

   ir_state_t   state_r, after_gap_r;
   logic [15:0] cnt_r;
   logic [2:0]  bit_idx_r;
   logic [7:0]  cmd_r, shadow_r;
   logic        ctrl_en_r, pending_r, busy_r, ir_led_r;

   ir_carrier_gen #(.PERIOD(CARRIER_DIV), .RISE_ONLY(1'b1)) u_carrier (
      .CLK   (CLK),
      .RESET (RESET),
      .level (carrier_s),
      .tick  (pulse_s)
   );

   ir_carrier_gen #(.PERIOD(PACKET_DIV), .RISE_ONLY(1'b0)) u_packet (
      .CLK   (CLK),
      .RESET (RESET),
      .level (pkt_level_unused_s),
      .tick  (pkt_tick_s)
   );

   // Bus decode, packet request sources and current segment length.
   always_comb begin
      cmd_wr_s   = BUS_WE && (BUS_ADDR == CMD_ADDR);
      ctrl_wr_s  = BUS_WE && (BUS_ADDR == CTRL_ADDR);
      cmd_new_s  = BUS_DATA & CMD_MASK;
      trig_s     = ctrl_wr_s && BUS_DATA[CTRL_TRIG_BIT];
`ifdef IR_CHANGE_TRIGGER_EN
      chg_s      = cmd_wr_s && (cmd_new_s != cmd_r);
`else
      chg_s      = 1'b0;
`endif
      set_pend_s = trig_s || (pkt_tick_s && ctrl_en_r) || chg_s;
      burst_s    = (state_r == START) || (state_r == CARSEL) || (state_r == BIT);
      case (state_r)
         START:   limit_s = last_tick(START_PULSES);
         CARSEL:  limit_s = last_tick(CARSEL_PULSES);
         BIT:     limit_s = shadow_r[bit_idx_r] ? last_tick(ONE_PULSES) : last_tick(ZERO_PULSES);
         default: limit_s = last_tick(GAP_PULSES);
      endcase
      end_s      = pulse_s && (cnt_r == limit_s);
   end

   // Command/control registers and the pending-packet flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cmd_r     <= 8'd0;
         ctrl_en_r <= 1'b0;
         pending_r <= 1'b0;
      end else begin
         if (cmd_wr_s)
            cmd_r <= cmd_new_s;
         if (ctrl_wr_s)
            ctrl_en_r <= BUS_DATA[CTRL_EN_BIT];
         // A new request in the same clock the FSM leaves IDLE stays pending.
         if (set_pend_s)
            pending_r <= 1'b1;
         else if ((state_r == IDLE) && pulse_s)
            pending_r <= 1'b0;
      end
   end

   // Packet sequencer: START, CARSEL, then one burst per command bit, each followed by a gap.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r     <= IDLE;
         after_gap_r <= IDLE;
         cnt_r       <= 16'd0;
         bit_idx_r   <= 3'd0;
         shadow_r    <= 8'd0;
         busy_r      <= 1'b0;
      end else begin
         if (pulse_s && (burst_s || (state_r == GAP)))
            cnt_r <= end_s ? 16'd0 : cnt_r + 16'd1;
         case (state_r)
            IDLE: begin
               if (pending_r && pulse_s) begin
                  state_r  <= START;
                  shadow_r <= cmd_r;
                  busy_r   <= 1'b1;
               end
            end
            START: begin
               if (end_s) begin
                  state_r     <= GAP;
                  after_gap_r <= CARSEL;
               end
            end
            CARSEL: begin
               if (end_s) begin
                  state_r     <= GAP;
                  after_gap_r <= BIT;
                  bit_idx_r   <= 3'd0;
               end
            end
            BIT: begin
               if (end_s) begin
                  state_r <= GAP;
                  if (bit_idx_r == LAST_BIT) begin
                     after_gap_r <= DONE;
                  end else begin
                     after_gap_r <= BIT;
                     bit_idx_r   <= bit_idx_r + 3'd1;
                  end
               end
            end
            GAP: begin
               if (end_s)
                  state_r <= after_gap_r;
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Registered LED drive: carrier gated by burst, one clock behind state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         ir_led_r <= 1'b0;
      else
         ir_led_r <= carrier_s && burst_s;
   end

   assign IR_LED = ir_led_r;
   assign BUSY   = busy_r;

endmodule

// File: tb/tb_ir_transmitter_gen.sv
// Self-checking bench for ir_transmitter_gen: packet schedule model as a list of
// carrier periods (burst/silent) checked every clock, plus hand-computed packet figures.
module tb_ir_transmitter_gen;

`ifdef IR_CHANGE_TRIGGER_EN
   localparam bit CHG = 1'b1;
`else
   localparam bit CHG = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] BUS_ADDR = 8'h00;
   logic [7:0] BUS_DATA = 8'h00;
   logic       BUS_WE = 1'b0;
   logic       IR_LED, BUSY;

   int checks = 0;
   int errors = 0;

   ir_transmitter_gen #(
      .BASE_ADDR(8'h90), .CLK_FREQ_HZ(80), .CARRIER_HZ(10), .PACKET_HZ(1), .CMD_BITS(4),
      .START_PULSES(4), .CARSEL_PULSES(2), .GAP_PULSES(2), .ONE_PULSES(3), .ZERO_PULSES(1)
   ) dut (
      .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
      .BUS_WE(BUS_WE), .IR_LED(IR_LED), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: carrier period is 8 clocks, rising at edges k%8==4; packet ticks at k%80==0.
   int         k;
   bit         m_pend, m_en;
   logic [7:0] m_cmd;
   int         pkt_s;
   bit         seg[$];
   bit         exp_busy, exp_led, exp_burst, exp_car;
   bit         wr_c, wr_t, start_now, set_now;
   int         j;

   task automatic add_seg(input int n);
      for (int i = 0; i < n; i++) seg.push_back(1'b1);
      for (int i = 0; i < 2; i++) seg.push_back(1'b0);
   endtask

   task automatic build_packet(input logic [7:0] c);
      seg.delete();
      add_seg(4);
      add_seg(2);
      for (int i = 0; i < 4; i++) add_seg(c[i] ? 3 : 1);
   endtask

   initial forever begin
      @(posedge CLK);
      if (RESET) begin
         k = 0; m_pend = 0; m_en = 0; m_cmd = 8'h00; pkt_s = -1;
         exp_busy = 0; exp_led = 0; exp_burst = 0; exp_car = 0;
      end else begin
         k++;
         exp_led   = exp_car & exp_burst;
         wr_c      = BUS_WE && (BUS_ADDR == 8'h90);
         wr_t      = BUS_WE && (BUS_ADDR == 8'h91);
         start_now = !exp_busy && m_pend && (k % 8 == 4);
         set_now   = (wr_t && BUS_DATA[1]) || ((k % 80 == 0) && m_en) ||
                     (CHG && wr_c && ((BUS_DATA & 8'h0F) != m_cmd));
         if (start_now) begin
            build_packet(m_cmd);
            pkt_s = k;
         end
         m_pend = set_now || (m_pend && !start_now);
         if (wr_c) m_cmd = BUS_DATA & 8'h0F;
         if (wr_t) m_en = BUS_DATA[0];
         exp_car = ((k / 4) % 2) == 1;
         if (pkt_s >= 0) begin
            j = k - pkt_s;
            if (j < 8 * seg.size() + 1) begin
               exp_busy  = 1;
               exp_burst = (j < 8 * seg.size()) && seg[j / 8];
            end else begin
               exp_busy  = 0;
               exp_burst = 0;
               pkt_s     = -1;
            end
         end else begin
            exp_busy  = 0;
            exp_burst = 0;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge CLK);
      if (!RESET) begin
         check("busy", int'(BUSY), int'(exp_busy));
         check("ir_led", int'(IR_LED), int'(exp_led));
      end
   end

   int pkt_count = 0;
   bit busy_q = 0;
   initial forever begin
      @(negedge CLK);
      if (BUSY && !busy_q) pkt_count++;
      busy_q = BUSY;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(posedge CLK); #1;
      BUS_WE = 1'b1; BUS_ADDR = a; BUS_DATA = d;
      @(posedge CLK); #1;
      BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA = 8'h00;
   endtask

   task automatic wait_busy(input bit v, input string name);
      int t = 0;
      while (BUSY !== v && t < 1000) begin
         @(negedge CLK);
         t++;
      end
      if (BUSY !== v) check(name, int'(BUSY), int'(v));
   endtask

   task automatic measure(output int bc, output int lr, output int ok);
      int t = 0;
      bit lq = 0;
      bc = 0; lr = 0; ok = 1;
      while (!BUSY && t < 400) begin
         @(negedge CLK);
         t++;
      end
      if (!BUSY) begin
         ok = 0;
         return;
      end
      while (BUSY && bc < 2000) begin
         if (IR_LED && !lq) lr++;
         lq = IR_LED;
         bc++;
         @(negedge CLK);
      end
   endtask

   int bc, lr, ok;
   logic [7:0] ra, rd;

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("reset_led", int'(IR_LED), 0);
      check("reset_busy", int'(BUSY), 0);
      RESET = 1'b0;

      pkt_count = 0;
      idle(200);
      check("idle_no_packet", pkt_count, 0);

      // One-shot of 0101: bursts 4,2,3,1,3,1 -> 14 LED pulses; 26 periods*8+1 busy clocks.
      wr(8'h90, 8'h05);
      wr(8'h91, 8'h02);
      measure(bc, lr, ok);
      check("oneshot_seen", ok, 1);
      check("oneshot_busy_len", bc, 209);
      check("oneshot_bursts", lr, 14);
      pkt_count = 0;
      idle(300);
      check("oneshot_no_repeat", pkt_count, 0);

      wr(8'h91, 8'h01);
      pkt_count = 0;
      idle(500);
      check("periodic_running", int'(pkt_count >= 2), 1);

      // Change CMD just after a packet starts; the following packet sends 1111.
      wait_busy(1'b0, "wait_busy_low");
      wait_busy(1'b1, "wait_busy_high");
      wr(8'h90, 8'h0F);
      wait_busy(1'b0, "wait_busy_low2");
      measure(bc, lr, ok);
      check("newcmd_seen", ok, 1);
      check("newcmd_busy_len", bc, 241);
      check("newcmd_bursts", lr, 18);
      wr(8'h91, 8'h00);
      idle(300);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       ra = 8'h90;
            1:       ra = 8'h91;
            2:       ra = 8'h91;
            default: ra = 8'($urandom);
         endcase
         rd = 8'($urandom);
         wr(ra, rd);
         idle($urandom_range(0, 60));
      end

      RESET = 1'b1;
      idle(3);
      RESET = 1'b0;
      idle(5);

      // Reset during the CARSEL burst (clocks 48..63 of the packet).
      wr(8'h91, 8'h02);
      wait_busy(1'b1, "carsel_wait_busy");
      repeat (50) @(posedge CLK);
      #1;
      check("pre_reset_led", int'(IR_LED), 1);
      RESET = 1'b1;
      #1;
      check("async_reset_led", int'(IR_LED), 0);
      check("async_reset_busy", int'(BUSY), 0);
      idle(3);
      RESET = 1'b0;
      pkt_count = 0;
      idle(300);
      check("no_packet_after_reset", pkt_count, 0);

      pkt_count = 0;
      wr(8'h90, 8'h03);
      wr(8'h90, 8'h03);
      idle(400);
      check("chg_same_twice", pkt_count, CHG ? 1 : 0);
      pkt_count = 0;
      wr(8'h90, 8'h04);
      idle(400);
      check("chg_new_value", pkt_count, CHG ? 1 : 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
